// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit is lit for SCAN_DIV cycles, separated by GAP_CYCLES of all-dark.
module seg7_scan_driver #(
  parameter logic [23:0] SCAN_DIV    = 24'd50_000,
  parameter logic [23:0] GAP_CYCLES  = 24'd16,
  parameter logic        LZ_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic {GAP = 1'b0, SHOW = 1'b1} state_t;

  state_t      state, nxt_state;
  logic [1:0]  idx, nxt_idx;
  logic [23:0] cnt, nxt_cnt;
  logic [15:0] sh_val, nxt_sh_val;
  logic [3:0]  sh_dp, nxt_sh_dp;
  logic        enter_show;
  logic [3:0]  nxt_an;
  logic [6:0]  nxt_seg;
  logic        nxt_dp, nxt_fd;
  logic [3:0]  nib;
  logic        suppress;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Next-state: the outputs are computed from the next state so they change
  // on the same edge as the phase they belong to.
  always_comb begin
    nxt_state  = state;
    nxt_idx    = idx;
    nxt_cnt    = cnt + 24'd1;
    nxt_sh_val = sh_val;
    nxt_sh_dp  = sh_dp;
    nxt_fd     = 1'b0;
    enter_show = 1'b0;
    if (!enable) begin
      nxt_state = GAP;
      nxt_idx   = 2'd0;
      nxt_cnt   = 24'd0;
    end else begin
      case (state)
        GAP: begin
          if (GAP_CYCLES == 24'd0 || cnt == GAP_CYCLES - 24'd1) begin
            nxt_state  = SHOW;
            nxt_cnt    = 24'd0;
            enter_show = 1'b1;
          end
        end
        default: begin
          if (cnt == SCAN_DIV - 24'd1) begin
            nxt_cnt = 24'd0;
            nxt_idx = idx + 2'd1;
            nxt_fd  = (idx == 2'd3);
            if (GAP_CYCLES == 24'd0) begin
              nxt_state  = SHOW;
              enter_show = 1'b1;
            end else begin
              nxt_state = GAP;
            end
          end
        end
      endcase
    end
    // Latch once per frame so a lit digit never changes mid-frame.
    if (enter_show && nxt_idx == 2'd0) begin
      nxt_sh_val = value;
      nxt_sh_dp  = dp_in;
    end
  end

  always_comb begin
    case (nxt_idx)
      2'd0: nib = nxt_sh_val[3:0];
      2'd1: nib = nxt_sh_val[7:4];
      2'd2: nib = nxt_sh_val[11:8];
      default: nib = nxt_sh_val[15:12];
    endcase
    case (nxt_idx)
      2'd1: suppress = LZ_SUPPRESS && (nxt_sh_val[15:4] == 12'h000);
      2'd2: suppress = LZ_SUPPRESS && (nxt_sh_val[15:8] == 8'h00);
      2'd3: suppress = LZ_SUPPRESS && (nxt_sh_val[15:12] == 4'h0);
      default: suppress = 1'b0;
    endcase
    nxt_an  = 4'b1111;
    nxt_seg = 7'h7F;
    nxt_dp  = 1'b1;
    if (nxt_state == SHOW) begin
      nxt_an  = ~(4'b0001 << nxt_idx);
      nxt_seg = suppress ? 7'h7F : decode(nib);
      nxt_dp  = ~nxt_sh_dp[nxt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GAP;
      idx        <= 2'd0;
      cnt        <= 24'd0;
      sh_val     <= 16'h0000;
      sh_dp      <= 4'h0;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      cnt        <= nxt_cnt;
      sh_val     <= nxt_sh_val;
      sh_dp      <= nxt_sh_dp;
      an         <= nxt_an;
      seg        <= nxt_seg;
      dp         <= nxt_dp;
      frame_done <= nxt_fd;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances cover the default
// scan (4/2), the no-suppression variant and the gapless 1-cycle scan.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic       fd_a, fd_b, fd_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(24'd4), .GAP_CYCLES(24'd2), .LZ_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a));

  seg7_scan_driver #(.SCAN_DIV(24'd4), .GAP_CYCLES(24'd2), .LZ_SUPPRESS(1'b0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b));

  seg7_scan_driver #(.SCAN_DIV(24'd1), .GAP_CYCLES(24'd0), .LZ_SUPPRESS(1'b1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .an(an_c), .seg(seg_c), .dp(dp_c), .frame_done(fd_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with enable low, check reset values, release on the falling edge
  // so the next rising edge is the first enabled one.
  task automatic do_reset(input logic [15:0] v, input logic [3:0] d);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    value  = v;
    dp_in  = d;
    #1;
    check("rst_an", an_a, 4'b1111);
    check("rst_seg", seg_a, 7'h7F);
    check("rst_dp", dp_a, 1'b1);
    check("rst_fd", fd_a, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic dark(input int n, input logic fd_first);
    for (int k = 0; k < n; k++) begin
      step();
      check("dark_an", an_a, 4'b1111);
      check("dark_seg", seg_a, 7'h7F);
      check("dark_dp", dp_a, 1'b1);
      check("dark_fd", fd_a, (k == 0) ? fd_first : 1'b0);
    end
  endtask

  task automatic lit(input int d, input logic [6:0] s, input logic dpv, input int n);
    logic [3:0] exp_an;
    exp_an = ~(4'b0001 << d);
    for (int k = 0; k < n; k++) begin
      step();
      check("lit_an", an_a, exp_an);
      check("lit_seg", seg_a, s);
      check("lit_dp", dp_a, dpv);
      check("lit_fd", fd_a, 1'b0);
    end
  endtask

  logic [6:0] seg_12af [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
  logic [6:0] seg_05_lz [4] = '{7'h12, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] seg_05_nolz [4] = '{7'h12, 7'h40, 7'h40, 7'h40};
  logic [3:0] an_rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic       dp_1010 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    value  = 16'h0000;
    dp_in  = 4'h0;

    // 1: basic frame, frame_done on the 24th enabled edge
    do_reset(16'h12AF, 4'h0);
    dark(1, 1'b0);
    for (int d = 0; d < 4; d++) begin
      lit(d, seg_12af[d], 1'b1, 4);
      dark(2, d == 3);
    end

    // 2: leading-zero suppression vs. none
    do_reset(16'h0005, 4'h0);
    dark(1, 1'b0);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        check("lz_an", an_a, an_rot[d]);
        check("lz_seg", seg_a, seg_05_lz[d]);
        check("nolz_an", an_b, an_rot[d]);
        check("nolz_seg", seg_b, seg_05_nolz[d]);
      end
      dark(2, d == 3);
    end

    // 3: value change mid-frame only shows in the next frame
    do_reset(16'h1111, 4'h0);
    dark(1, 1'b0);
    lit(0, 7'h79, 1'b1, 4);
    dark(2, 1'b0);
    lit(1, 7'h79, 1'b1, 2);
    value = 16'h2222;
    lit(1, 7'h79, 1'b1, 2);
    dark(2, 1'b0);
    lit(2, 7'h79, 1'b1, 4);
    dark(2, 1'b0);
    lit(3, 7'h79, 1'b1, 4);
    dark(2, 1'b1);
    for (int d = 0; d < 4; d++) begin
      lit(d, 7'h24, 1'b1, 4);
      dark(2, d == 3);
    end

    // 4: enable dropped mid-SHOW of digit 2
    do_reset(16'h12AF, 4'h0);
    dark(1, 1'b0);
    lit(0, 7'h0E, 1'b1, 4);
    dark(2, 1'b0);
    lit(1, 7'h08, 1'b1, 4);
    dark(2, 1'b0);
    lit(2, 7'h24, 1'b1, 2);
    enable = 1'b0;
    dark(5, 1'b0);
    enable = 1'b1;
    dark(1, 1'b0);
    lit(0, 7'h0E, 1'b1, 4);

    // 5: asynchronous reset between edges while a digit is lit
    lit(0, 7'h0E, 1'b1, 0);
    dark(2, 1'b0);
    lit(1, 7'h08, 1'b1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", an_a, 4'b1111);
    check("async_seg", seg_a, 7'h7F);
    check("async_dp", dp_a, 1'b1);
    check("async_fd", fd_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dark(1, 1'b0);
    lit(0, 7'h0E, 1'b1, 4);

    // 6: gapless single-cycle scan with decimal points on digits 1 and 3
    do_reset(16'h12AF, 4'b1010);
    for (int c = 1; c <= 12; c++) begin
      step();
      check("fast_an", an_c, an_rot[(c - 1) % 4]);
      check("fast_seg", seg_c, seg_12af[(c - 1) % 4]);
      check("fast_dp", dp_c, dp_1010[(c - 1) % 4]);
      check("fast_fd", fd_c, (c >= 5) && ((c - 1) % 4 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
